// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave that turns single read/write transactions into req/we/be/addr/wdata
// register accesses. Define AXI_LITE_REG_SLAVE_TIMEOUT_EN to bound the WAIT state.
module axi_lite_reg_slave #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   s_awvalid_i,
  output logic                   s_awready_o,
  input  logic [AddrWidth-1:0]   s_awaddr_i,
  input  logic                   s_wvalid_i,
  output logic                   s_wready_o,
  input  logic [DataWidth-1:0]   s_wdata_i,
  input  logic [DataWidth/8-1:0] s_wstrb_i,
  output logic                   s_bvalid_o,
  input  logic                   s_bready_i,
  output logic [1:0]             s_bresp_o,
  input  logic                   s_arvalid_i,
  output logic                   s_arready_o,
  input  logic [AddrWidth-1:0]   s_araddr_i,
  output logic                   s_rvalid_o,
  input  logic                   s_rready_i,
  output logic [DataWidth-1:0]   s_rdata_o,
  output logic [1:0]             s_rresp_o,
  output logic                   reg_req_o,
  output logic                   reg_we_o,
  output logic [DataWidth/8-1:0] reg_be_o,
  output logic [AddrWidth-1:0]   reg_addr_o,
  output logic [DataWidth-1:0]   reg_wdata_o,
  input  logic                   reg_rvalid_i,
  input  logic [DataWidth-1:0]   reg_rdata_i,
  input  logic                   reg_err_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam logic [AddrWidth-1:0] WordMask = ~AddrWidth'(3);

  typedef enum logic [1:0] {StIdle, StReg, StWait, StResp} state_e;

  state_e                state_q;
  logic                  prio_q;
  logic                  awready_q, wready_q, arready_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DataWidth-1:0]  rdata_q;
  logic                  reg_req_q, reg_we_q;
  logic [StrbWidth-1:0]  reg_be_q;
  logic [AddrWidth-1:0]  reg_addr_q;
  logic [DataWidth-1:0]  reg_wdata_q;

  logic wr_elig, rd_elig, sel_wr, sel_rd;
  logic wr_hs, rd_hs, done_hs;
  logic timeout_hit, wait_done;
  logic [1:0] resp_d;

`ifdef AXI_LITE_REG_SLAVE_TIMEOUT_EN
  localparam int unsigned CntWidth =
      ($clog2(TimeoutCycles + 1) > 8) ? $clog2(TimeoutCycles + 1) : 8;

  logic [CntWidth-1:0] cnt_q;

  assign timeout_hit = (state_q == StWait) && !reg_rvalid_i &&
                       (cnt_q == CntWidth'(TimeoutCycles - 1));

  // Counts WAIT cycles without a completion; cleared whenever WAIT is left.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == StWait && !reg_rvalid_i && !timeout_hit) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    wr_elig   = s_awvalid_i & s_wvalid_i;
    rd_elig   = s_arvalid_i;
    sel_rd    = rd_elig & (~wr_elig | prio_q);
    sel_wr    = wr_elig & ~sel_rd;
    wr_hs     = awready_q & wready_q & wr_elig;
    rd_hs     = arready_q & rd_elig;
    done_hs   = (bvalid_q & s_bready_i) | (rvalid_q & s_rready_i);
    wait_done = reg_rvalid_i | timeout_hit;
    // A timeout reports SLVERR exactly like a device error.
    resp_d    = (reg_rvalid_i ? reg_err_i : 1'b1) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
      reg_req_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_be_q    <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
    end else begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      reg_req_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_hs) begin
            state_q     <= StReg;
            reg_req_q   <= 1'b1;
            reg_we_q    <= 1'b1;
            reg_be_q    <= s_wstrb_i;
            reg_addr_q  <= s_awaddr_i & WordMask;
            reg_wdata_q <= s_wdata_i;
            prio_q      <= 1'b1;
          end else if (rd_hs) begin
            state_q    <= StReg;
            reg_req_q  <= 1'b1;
            reg_we_q   <= 1'b0;
            reg_be_q   <= '1;
            reg_addr_q <= s_araddr_i & WordMask;
            prio_q     <= 1'b0;
          end else if (!awready_q && !arready_q) begin
            // Ready is offered one cycle after the winner is picked; an offered
            // ready that finds no valid simply lapses and arbitration reruns.
            awready_q <= sel_wr;
            wready_q  <= sel_wr;
            arready_q <= sel_rd;
          end
        end
        StReg: begin
          state_q <= StWait;
        end
        StWait: begin
          if (wait_done) begin
            state_q <= StResp;
            if (reg_we_q) begin
              bvalid_q <= 1'b1;
              bresp_q  <= resp_d;
              rdata_q  <= '0;
            end else begin
              rvalid_q <= 1'b1;
              rresp_q  <= resp_d;
              rdata_q  <= reg_rvalid_i ? reg_rdata_i : '0;
            end
          end
        end
        StResp: begin
          if (done_hs) begin
            state_q   <= StIdle;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            // Arbitrate on the handshake edge so back-to-back traffic turns in 4 cycles.
            awready_q <= sel_wr;
            wready_q  <= sel_wr;
            arready_q <= sel_rd;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign s_awready_o = awready_q;
  assign s_wready_o  = wready_q;
  assign s_arready_o = arready_q;
  assign s_bvalid_o  = bvalid_q;
  assign s_bresp_o   = bresp_q;
  assign s_rvalid_o  = rvalid_q;
  assign s_rresp_o   = rresp_q;
  assign s_rdata_o   = rdata_q;
  assign reg_req_o   = reg_req_q;
  assign reg_we_o    = reg_we_q;
  assign reg_be_o    = reg_be_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: transaction-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_axi_lite_reg_slave;

  localparam int unsigned To = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_awvalid_i, s_awready_o;
  logic [31:0] s_awaddr_i;
  logic        s_wvalid_i, s_wready_o;
  logic [31:0] s_wdata_i;
  logic [3:0]  s_wstrb_i;
  logic        s_bvalid_o, s_bready_i;
  logic [1:0]  s_bresp_o;
  logic        s_arvalid_i, s_arready_o;
  logic [31:0] s_araddr_i;
  logic        s_rvalid_o, s_rready_i;
  logic [31:0] s_rdata_o;
  logic [1:0]  s_rresp_o;
  logic        reg_req_o, reg_we_o;
  logic [3:0]  reg_be_o;
  logic [31:0] reg_addr_o, reg_wdata_o;
  logic        reg_rvalid_i;
  logic [31:0] reg_rdata_i;
  logic        reg_err_i;

  always #5 clk = ~clk;

  axi_lite_reg_slave #(
    .AddrWidth    (32),
    .DataWidth    (32),
    .TimeoutCycles(To)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_awvalid_i  (s_awvalid_i),
    .s_awready_o  (s_awready_o),
    .s_awaddr_i   (s_awaddr_i),
    .s_wvalid_i   (s_wvalid_i),
    .s_wready_o   (s_wready_o),
    .s_wdata_i    (s_wdata_i),
    .s_wstrb_i    (s_wstrb_i),
    .s_bvalid_o   (s_bvalid_o),
    .s_bready_i   (s_bready_i),
    .s_bresp_o    (s_bresp_o),
    .s_arvalid_i  (s_arvalid_i),
    .s_arready_o  (s_arready_o),
    .s_araddr_i   (s_araddr_i),
    .s_rvalid_o   (s_rvalid_o),
    .s_rready_i   (s_rready_i),
    .s_rdata_o    (s_rdata_o),
    .s_rresp_o    (s_rresp_o),
    .reg_req_o    (reg_req_o),
    .reg_we_o     (reg_we_o),
    .reg_be_o     (reg_be_o),
    .reg_addr_o   (reg_addr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_rvalid_i (reg_rvalid_i),
    .reg_rdata_i  (reg_rdata_i),
    .reg_err_i    (reg_err_i)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Device behaviour, set by the directed sequence.
  int          dev_delay = 0;  // extra cycles before completion; negative = never answer
  logic [31:0] dev_rdata = '0;
  logic        dev_err   = 1'b0;
  int          stray_cnt = 0;

  initial begin
    int d;
    int stray_done;
    stray_done   = 0;
    reg_rvalid_i = 1'b0;
    reg_rdata_i  = '0;
    reg_err_i    = 1'b0;
    forever begin
      @(negedge clk);
      if (stray_cnt != stray_done) begin
        stray_done++;
        @(posedge clk); #1;
        reg_rvalid_i = 1'b1; reg_rdata_i = 32'hBAD0BAD0; reg_err_i = 1'b1;
        @(posedge clk); #1;
        reg_rvalid_i = 1'b0;
      end else if (!rst && reg_req_o && dev_delay >= 0) begin
        d = dev_delay;
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1;
        reg_rvalid_i = 1'b1; reg_rdata_i = dev_rdata; reg_err_i = dev_err;
        @(posedge clk); #1;
        reg_rvalid_i = 1'b0;
      end
    end
  end

  // Transaction-level model: accepted transactions queue up, each yields one
  // register access and then one response whose content follows from the device.
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          hs;
  } acc_t;

  acc_t        pend[$];
  acc_t        cur;
  acc_t        mdl_a;
  bit          inflight = 0;
  bit          resolved = 0;
  int          req_cyc, exp_vcyc;
  logic [1:0]  exp_resp;
  logic [31:0] exp_data;
  logic [31:0] last_req_addr, last_rdata;
  logic        last_req_we;
  logic [3:0]  last_req_be;
  logic [1:0]  last_bresp, last_rresp;
  int          last_lat;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
        inflight = 0;
        resolved = 0;
      end else begin
        if (inflight || pend.size() != 0)
          check("ready_when_busy", {s_awready_o, s_wready_o, s_arready_o}, 3'b000);
        if (s_awvalid_i && s_awready_o && s_wvalid_i && s_wready_o) begin
          mdl_a.we = 1; mdl_a.addr = {s_awaddr_i[31:2], 2'b00}; mdl_a.be = s_wstrb_i;
          mdl_a.wdata = s_wdata_i; mdl_a.hs = cyc;
          pend.push_back(mdl_a);
        end
        if (s_arvalid_i && s_arready_o) begin
          mdl_a.we = 0; mdl_a.addr = {s_araddr_i[31:2], 2'b00}; mdl_a.be = 4'hF;
          mdl_a.wdata = '0; mdl_a.hs = cyc;
          pend.push_back(mdl_a);
        end

        if (reg_req_o) begin
          if (pend.size() == 0 || inflight) begin
            check("req_spurious", reg_req_o, 1'b0);
          end else begin
            cur = pend.pop_front();
            inflight = 1; resolved = 0; req_cyc = cyc;
            check("req_latency", cyc - cur.hs, 1);
            check("req_we", reg_we_o, cur.we);
            check("req_addr", reg_addr_o, cur.addr);
            check("req_be", reg_be_o, cur.be);
            if (cur.we) check("req_wdata", reg_wdata_o, cur.wdata);
            last_req_addr = reg_addr_o; last_req_we = reg_we_o; last_req_be = reg_be_o;
          end
        end else if (inflight && !resolved) begin
          if (reg_rvalid_i) begin
            resolved = 1; exp_vcyc = cyc + 1;
            exp_resp = reg_err_i ? 2'b10 : 2'b00;
            exp_data = cur.we ? 32'h0 : reg_rdata_i;
          end
`ifdef AXI_LITE_REG_SLAVE_TIMEOUT_EN
          else if (cyc == req_cyc + int'(To)) begin
            resolved = 1; exp_vcyc = cyc + 1;
            exp_resp = 2'b10; exp_data = 32'h0;
          end
`endif
        end

        if (s_bvalid_o || s_rvalid_o) begin
          if (!(inflight && resolved && cyc >= exp_vcyc)) begin
            check("valid_spurious", {s_bvalid_o, s_rvalid_o}, 2'b00);
          end else begin
            check("valid_channel", {s_bvalid_o, s_rvalid_o}, cur.we ? 2'b10 : 2'b01);
            if (cur.we) begin
              check("bresp", s_bresp_o, exp_resp);
              last_bresp = s_bresp_o;
            end else begin
              check("rresp", s_rresp_o, exp_resp);
              check("rdata", s_rdata_o, exp_data);
              last_rresp = s_rresp_o; last_rdata = s_rdata_o;
            end
            if ((cur.we && s_bready_i) || (!cur.we && s_rready_i)) begin
              last_lat = cyc - cur.hs;
              inflight = 0; resolved = 0;
            end
          end
        end else if (inflight && resolved && cyc >= exp_vcyc) begin
          check("valid_missing", {s_bvalid_o, s_rvalid_o}, cur.we ? 2'b10 : 2'b01);
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output int hs);
    int n;
    n = 0; hs = -1;
    @(posedge clk); #1;
    s_awvalid_i = 1'b1; s_awaddr_i = a; s_wvalid_i = 1'b1; s_wdata_i = d; s_wstrb_i = s;
    while (hs < 0 && n < 200) begin
      @(negedge clk);
      if (s_awready_o && s_wready_o) hs = cyc;
      n++;
    end
    check("wr_accepted", hs >= 0, 1'b1);
    @(posedge clk); #1;
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output int hs);
    int n;
    n = 0; hs = -1;
    @(posedge clk); #1;
    s_arvalid_i = 1'b1; s_araddr_i = a;
    while (hs < 0 && n < 200) begin
      @(negedge clk);
      if (s_arready_o) hs = cyc;
      n++;
    end
    check("rd_accepted", hs >= 0, 1'b1);
    @(posedge clk); #1;
    s_arvalid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk); #1;
    while ((inflight || pend.size() != 0) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("idle_reached", n < 200, 1'b1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_awready"}, s_awready_o, 1'b0);
    check({tag, "_wready"},  s_wready_o,  1'b0);
    check({tag, "_arready"}, s_arready_o, 1'b0);
    check({tag, "_bvalid"},  s_bvalid_o,  1'b0);
    check({tag, "_rvalid"},  s_rvalid_o,  1'b0);
    check({tag, "_req"},     reg_req_o,   1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int whs, rhs, n;
    rst = 1'b1;
    s_awvalid_i = 0; s_awaddr_i = '0; s_wvalid_i = 0; s_wdata_i = '0; s_wstrb_i = '0;
    s_arvalid_i = 0; s_araddr_i = '0; s_bready_i = 1; s_rready_i = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("rst");
    check("rst_bresp", s_bresp_o, 2'b00);
    check("rst_rresp", s_rresp_o, 2'b00);
    check("rst_rdata", s_rdata_o, 32'h0);
    check("rst_addr", reg_addr_o, 32'h0);
    check("rst_wdata", reg_wdata_o, 32'h0);
    check("rst_be", reg_be_o, 4'h0);
    check("rst_we", reg_we_o, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic write with one-cycle device turnaround.
    dev_delay = 0; dev_err = 0;
    wr(32'h0004_0004, 32'hDEAD_BEEF, 4'hF, whs);
    wait_idle();
    check("t1_addr", last_req_addr, 32'h0004_0004);
    check("t1_we", last_req_we, 1'b1);
    check("t1_be", last_req_be, 4'hF);
    check("t1_latency", last_lat, 3);
    check("t1_bresp", last_bresp, 2'b00);

    // Read held off by rready for 5 cycles.
    dev_rdata = 32'h1234_5678;
    s_rready_i = 1'b0;
    rd(32'h0004_0008, rhs);
    n = 0;
    while (!s_rvalid_o && n < 50) begin @(negedge clk); n++; end
    check("t2_rvalid_seen", s_rvalid_o, 1'b1);
    repeat (5) @(negedge clk);
    check("t2_rvalid_held", s_rvalid_o, 1'b1);
    check("t2_rdata_held", s_rdata_o, 32'h1234_5678);
    @(posedge clk); #1 s_rready_i = 1'b1;
    wait_idle();
    check("t2_rresp", last_rresp, 2'b00);
    check("t2_rdata", last_rdata, 32'h1234_5678);

    // Arbitration: after reset writes win, then prio alternates by last served type.
    pulse_reset();
    dev_rdata = 32'hA5A5_0001;
    fork
      wr(32'h0000_0100, 32'h0000_1111, 4'h3, whs);
      rd(32'h0000_0200, rhs);
    join
    wait_idle();
    check("arb1_write_first", rhs - whs, 4);
    fork
      wr(32'h0000_0104, 32'h0000_2222, 4'hC, whs);
      rd(32'h0000_0204, rhs);
    join
    wait_idle();
    check("arb2_write_first", rhs - whs, 4);
    wr(32'h0000_0108, 32'h0000_3333, 4'hF, whs);
    wait_idle();
    fork
      wr(32'h0000_010C, 32'h0000_4444, 4'h1, whs);
      rd(32'h0000_020C, rhs);
    join
    wait_idle();
    check("arb3_read_first", whs - rhs, 4);

    // Device errors map to SLVERR; read data passes through, address is word-aligned.
    dev_err = 1; dev_rdata = 32'hCAFE_F00D;
    rd(32'h0000_0300, rhs);
    wait_idle();
    check("t4_rresp", last_rresp, 2'b10);
    check("t4_rdata", last_rdata, 32'hCAFE_F00D);
    dev_delay = 2;
    wr(32'h1000_0003, 32'h5555_AAAA, 4'h5, whs);
    wait_idle();
    check("t4_bresp", last_bresp, 2'b10);
    check("t4_addr_aligned", last_req_addr, 32'h1000_0000);
    check("t4_be", last_req_be, 4'h5);
    dev_err = 0; dev_delay = 0;

`ifdef AXI_LITE_REG_SLAVE_TIMEOUT_EN
    dev_delay = -1;
    rd(32'h0000_0400, rhs);
    wait_idle();
    check("t5_rresp", last_rresp, 2'b10);
    check("t5_rdata", last_rdata, 32'h0);
    check("t5_latency", last_lat, int'(To) + 2);
    stray_cnt++;
    repeat (6) @(negedge clk);
    check("t5_no_stray_rvalid", s_rvalid_o, 1'b0);
    check("t5_no_stray_bvalid", s_bvalid_o, 1'b0);
    dev_delay = 0;
`endif

    // Reset while the access is stuck in WAIT.
    dev_delay = -1;
    rd(32'h0000_0500, rhs);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_quiet("wait_rst");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("post_rst");
    dev_delay = 0;
    wr(32'h0000_0500, 32'h1122_3344, 4'h3, whs);
    wait_idle();
    check("t6_addr", last_req_addr, 32'h0000_0500);
    check("t6_bresp", last_bresp, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
